axis_stream_fifo: RTL
=====================

AXIS_STREAM_FIFO -- requirements
Module: axis_stream_fifo

Interface
REQ-001 Parameter WIDTH, default 16, tdata width in bits (1..64).
REQ-002 Parameter DEPTH, default 16, storage depth in words; SHALL be a power of 2, 2..1024.
REQ-003 i_clk  in  1  processor clock; all state SHALL change on its rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 s_axis_tvalid  in  1  upstream word valid.
REQ-006 s_axis_tready  out  1  FIFO can accept a word.
REQ-007 s_axis_tlast  in  1  upstream end-of-packet marker.
REQ-008 s_axis_tdata  in  WIDTH  upstream data.
REQ-009 m_axis_tvalid  out  1  head word available to the downstream AXI_Stream_Slave peripheral.
REQ-010 m_axis_tready  in  1  downstream accepts the head word.
REQ-011 m_axis_tlast  out  1  tlast stored with the head word.
REQ-012 m_axis_tdata  out  WIDTH  head word data.
REQ-013 o_count  out  clog2(DEPTH)+1  number of words stored.

Function
REQ-014 Push SHALL occur on an edge where s_axis_tvalid and s_axis_tready are both high; pop SHALL occur on an edge where m_axis_tvalid and m_axis_tready are both high.
REQ-015 Each push SHALL store {tlast, tdata} at the write pointer; each pop SHALL advance the read pointer; pointers SHALL wrap modulo DEPTH.
REQ-016 s_axis_tready SHALL equal (o_count != DEPTH), from registered state only; there SHALL be no combinational path from m_axis_tready to s_axis_tready.
REQ-017 Output SHALL be first-word-fall-through: m_axis_tdata/m_axis_tlast SHALL reflect the word at the read pointer whenever m_axis_tvalid is high.
REQ-018 Latency: a word pushed into an empty FIFO at edge N SHALL have m_axis_tvalid high in the cycle after edge N; there is no same-cycle bypass.
REQ-019 o_count SHALL increment on push-only, decrement on pop-only, and hold on simultaneous push and pop.
REQ-020 Simultaneous push and pop SHALL be allowed at any non-full, non-empty level; at full only pop occurs (tready low); at empty only push occurs (tvalid low).
REQ-021 m_axis_tvalid, once high, SHALL remain high with tdata/tlast stable until the pop edge.
REQ-022 Data order and tlast placement SHALL be preserved exactly; no words dropped or duplicated.

Reset
REQ-023 Asserting i_rst SHALL immediately clear pointers, o_count and packet counter, forcing s_axis_tready=0 while asserted, m_axis_tvalid=0, m_axis_tlast=0, o_count=0.
REQ-024 Reset mid-packet SHALL discard all stored words; storage contents need not be cleared; m_axis_tdata is don't-care while m_axis_tvalid is low.
REQ-025 s_axis_tready SHALL go high on the first edge after i_rst deasserts.

Configuration
REQ-026 Macro AXIS_STREAM_FIFO_PACKET_MODE_EN SHALL select packet mode when defined.
REQ-027 Defined: an internal packet counter SHALL count stored words with tlast (+1 on push with tlast, -1 on pop with tlast, hold on both); m_axis_tvalid SHALL be (o_count!=0) and (packet counter!=0 or o_count==DEPTH).
REQ-028 Defined: the full-without-tlast release (o_count==DEPTH) SHALL prevent deadlock on packets longer than DEPTH.
REQ-029 Not defined: no packet counter; m_axis_tvalid SHALL be (o_count!=0).

Verification
REQ-030 After reset, push 10 words 0x0051,0x0040,...,0x0000 (ix*ix, ix=9..0, tlast on last), m_axis_tready=1 -> same 10 words out in order, tlast only on 0x0000, o_count returns 0.
REQ-031 m_axis_tready=0, push until full with DEPTH=16 -> s_axis_tready low after 16th push, o_count=16; raise m_axis_tready for one cycle -> one pop, tready high next cycle.
REQ-032 Both sides valid/ready continuously at o_count=5 for 20 cycles -> o_count stays 5, throughput one word/cycle, order preserved.
REQ-033 PACKET_MODE_EN defined: push 3 words without tlast -> m_axis_tvalid stays 0; push 4th with tlast -> m_axis_tvalid 1 next cycle, 4 words emitted; 20-word packet, DEPTH=16 -> release at full, all 20 delivered.
REQ-034 Assert i_rst asynchronously with o_count=7 -> m_axis_tvalid and o_count go 0 without a clock edge; after release, new word 0x1234 is the first emitted.

Source files
------------

// File: rtl/axis_stream_fifo.sv
// axis_stream_fifo
//   AXI-Stream FIFO with first-word-fall-through output. Each stored entry
//   is {tlast, tdata}. Read and write pointers wrap modulo DEPTH.
//   Define AXIS_STREAM_FIFO_PACKET_MODE_EN to hold back the output until a
//   complete packet (a word carrying tlast) is stored, or until the FIFO is
//   full. The full case stops packets longer than DEPTH from deadlocking.
//
// Parameters
//   WIDTH  tdata width in bits (1..64)
//   DEPTH  storage depth in words, a power of 2 (2..1024)
//
// Ports
//   i_clk          clock; every state change happens on its rising edge
//   i_rst          asynchronous active-high reset
//   s_axis_tvalid  upstream word valid
//   s_axis_tready  FIFO can accept a word (registered state only)
//   s_axis_tlast   upstream end-of-packet marker
//   s_axis_tdata   upstream data
//   m_axis_tvalid  head word available downstream
//   m_axis_tready  downstream accepts the head word
//   m_axis_tlast   tlast stored with the head word
//   m_axis_tdata   head word data
//   o_count        number of words stored
module axis_stream_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  input  logic [WIDTH-1:0]         s_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [WIDTH-1:0]         m_axis_tdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  // Up/down level counter step: +1 on inc only, -1 on dec only, else hold.
  function automatic logic [AW:0] next_level(input logic [AW:0] level,
                                             input logic inc,
                                             input logic dec);
    logic [AW:0] result;
    result = level;
    if (inc && !dec)
      result = level + ONE;
    else if (dec && !inc)
      result = level - ONE;
    return result;
  endfunction

  logic [WIDTH:0]  mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            run;
  logic [WIDTH:0]  head;
  logic            push;
  logic            pop;
  logic            full;

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign push  = s_axis_tvalid & s_axis_tready;
  assign pop   = m_axis_tvalid & m_axis_tready;

  // run is cleared by reset and set on the first edge after release. This
  // keeps tready low for the whole reset and for the rest of that cycle.
  assign s_axis_tready = run & ~full;

`ifdef AXIS_STREAM_FIFO_PACKET_MODE_EN
  logic [AW:0] pkt_cnt;

  // Release the head once a whole packet is stored. A full FIFO with no
  // tlast inside is released as well, because it could never complete.
  assign m_axis_tvalid = (count != '0) & ((pkt_cnt != '0) | full);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      pkt_cnt <= '0;
    else
      pkt_cnt <= next_level(pkt_cnt, push & s_axis_tlast, pop & head[WIDTH]);
  end
`else
  assign m_axis_tvalid = (count != '0);
`endif

  assign m_axis_tlast = m_axis_tvalid & head[WIDTH];
  assign m_axis_tdata = head[WIDTH-1:0];
  assign o_count      = count;

  // Storage array; the contents survive reset because the pointers are
  // cleared, so old words can never become visible again.
  always_ff @(posedge i_clk) begin
    if (push)
      mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
  end

  // Pointers and level. The AW-bit pointers wrap modulo DEPTH by themselves.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      run    <= 1'b0;
    end else begin
      run <= 1'b1;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= next_level(count, push, pop);
    end
  end

endmodule
